// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - RV32I fetch stage: single-outstanding imem requests, response FIFO, IF/ID register
// A FIFO slot is reserved before each request, so responses can always be pushed.
module if_fetch_stage #(
  parameter int                      WORD_LENGTH       = 32,
  parameter int                      FIFO_DEPTH        = 2,
  parameter logic [WORD_LENGTH-1:0]  NOP_INSTR         = 32'h0000_0013,
  parameter logic [31:0]             PC_RESET_SENTINEL = 32'hFFFF_FFFC
) (
  input  logic                   CLK,
  input  logic                   Reset,
  input  logic [31:0]            PC,
  input  logic                   Stall,
  input  logic                   Flush,
  output logic                   IMemReq,
  output logic [31:0]            IMemAddr,
  input  logic                   IMemAck,
  input  logic                   IMemRValid,
  input  logic [WORD_LENGTH-1:0] IMemRData,
  output logic                   RetainPC,
  output logic [31:0]            IF_ID_PC,
  output logic [WORD_LENGTH-1:0] IF_ID_Instr,
  output logic                   IF_ID_Valid
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_WAIT} fetch_state_t;

  fetch_state_t state, state_next;
  logic         discard, discard_next;
  logic [31:0]  req_pc;

  logic [31:0]            fifo_pc    [FIFO_DEPTH];
  logic [WORD_LENGTH-1:0] fifo_instr [FIFO_DEPTH];
  logic [PTR_W-1:0]       rd_ptr, wr_ptr;
  logic [CNT_W-1:0]       count;

  logic pc_valid, room, accept, push, pop, nonempty;

  assign pc_valid = (PC != PC_RESET_SENTINEL);
  assign room     = (count < DEPTH_C);
  assign nonempty = (count != '0);

  assign IMemReq  = ~Reset & (state == S_IDLE) & pc_valid & ~Flush & room;
  assign IMemAddr = {PC[31:2], 2'b00};
  assign accept   = IMemReq & IMemAck;

  // The PC only computes a redirect target while RetainPC is low, so Flush forces it low.
  assign RetainPC = ~(Reset | Flush | ~pc_valid | accept);

  assign push = (state == S_WAIT) & IMemRValid & ~discard & ~Flush;
  assign pop  = ~Flush & ~Stall & nonempty;

  always_comb begin
    state_next   = state;
    discard_next = discard;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_next   = S_WAIT;
          discard_next = 1'b0;
        end
      end
      S_WAIT: begin
        if (IMemRValid) begin
          state_next = S_IDLE;
        end else if (Flush) begin
          discard_next = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state   <= S_IDLE;
      discard <= 1'b0;
      req_pc  <= '0;
    end else begin
      state   <= state_next;
      discard <= discard_next;
      if (accept) begin
        req_pc <= PC;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= req_pc;
      fifo_instr[wr_ptr] <= IMemRData;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (Flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Pop reads the pre-push head, so a new entry reaches IF/ID one cycle after its push.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      IF_ID_PC    <= '0;
      IF_ID_Instr <= NOP_INSTR;
      IF_ID_Valid <= 1'b0;
    end else if (Flush) begin
      IF_ID_Instr <= NOP_INSTR;
      IF_ID_Valid <= 1'b0;
    end else if (!Stall) begin
      if (nonempty) begin
        IF_ID_PC    <= fifo_pc[rd_ptr];
        IF_ID_Instr <= fifo_instr[rd_ptr];
        IF_ID_Valid <= 1'b1;
      end else begin
        IF_ID_Instr <= NOP_INSTR;
        IF_ID_Valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - directed self-checking bench for if_fetch_stage
// Inputs change 1 time unit after each rising edge; outputs are checked 1 unit later.
module tb_if_fetch_stage;

  logic        CLK;
  logic        Reset;
  logic [31:0] PC;
  logic        Stall;
  logic        Flush;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemAck;
  logic        IMemRValid;
  logic [31:0] IMemRData;
  logic        RetainPC;
  logic [31:0] IF_ID_PC;
  logic [31:0] IF_ID_Instr;
  logic        IF_ID_Valid;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] D0  = 32'h0050_0093;
  localparam logic [31:0] D4  = 32'h0010_0113;
  localparam logic [31:0] D8  = 32'h0020_0193;
  localparam logic [31:0] D12 = 32'h0030_8213;
  localparam logic [31:0] D40 = 32'h0000_0513;
  localparam logic [31:0] D44 = 32'h0010_0593;
  localparam logic [31:0] D48 = 32'h0020_0613;

  if_fetch_stage dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .PC          (PC),
    .Stall       (Stall),
    .Flush       (Flush),
    .IMemReq     (IMemReq),
    .IMemAddr    (IMemAddr),
    .IMemAck     (IMemAck),
    .IMemRValid  (IMemRValid),
    .IMemRData   (IMemRData),
    .RetainPC    (RetainPC),
    .IF_ID_PC    (IF_ID_PC),
    .IF_ID_Instr (IF_ID_Instr),
    .IF_ID_Valid (IF_ID_Valid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
    IMemAck    = 1'b0;
    IMemRValid = 1'b0;
    Flush      = 1'b0;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    Reset = 1'b1; PC = 32'hFFFF_FFFC; Stall = 1'b0; Flush = 1'b0;
    IMemAck = 1'b0; IMemRValid = 1'b0; IMemRData = '0;
    #3;
    chk("rst_req", IMemReq, 0);
    chk("rst_retain", RetainPC, 0);
    chk("rst_valid", IF_ID_Valid, 0);
    chk("rst_instr", IF_ID_Instr, NOP);
    chk("rst_pc", IF_ID_PC, 0);

    // C0: release, sentinel PC
    cyc(); Reset = 1'b0; settle();
    chk("c0_retain", RetainPC, 0);
    chk("c0_req", IMemReq, 0);
    // C1: PC=0 accepted
    cyc(); PC = 32'h0; IMemAck = 1'b1; settle();
    chk("c1_req", IMemReq, 1);
    chk("c1_addr", IMemAddr, 32'h0);
    chk("c1_retain", RetainPC, 0);
    // C2: response
    cyc(); PC = 32'h4; IMemRValid = 1'b1; IMemRData = D0; settle();
    chk("c2_req_wait", IMemReq, 0);
    chk("c2_retain", RetainPC, 1);
    // C3: issue PC=4, pop D0
    cyc(); IMemAck = 1'b1; settle();
    chk("c3_valid_bubble", IF_ID_Valid, 0);
    chk("c3_addr", IMemAddr, 32'h4);
    // C4: IF/ID shows PC 0; start stall
    cyc(); PC = 32'h8; Stall = 1'b1; IMemRValid = 1'b1; IMemRData = D4; settle();
    chk("c4_valid", IF_ID_Valid, 1);
    chk("c4_pc", IF_ID_PC, 32'h0);
    chk("c4_instr", IF_ID_Instr, D0);
    // C5: one entry buffered, request PC 8
    cyc(); IMemAck = 1'b1; settle();
    chk("c5_req", IMemReq, 1);
    chk("c5_addr", IMemAddr, 32'h8);
    // C6: second response fills FIFO
    cyc(); PC = 32'hC; IMemRValid = 1'b1; IMemRData = D8; settle();
    // C7..C9: full, stalled
    for (int i = 0; i < 3; i++) begin
      cyc(); IMemAck = 1'b1; settle();
      chk("full_req", IMemReq, 0);
      chk("full_retain", RetainPC, 1);
      chk("full_ifid_pc", IF_ID_PC, 32'h0);
    end
    // C10: release stall, memory holds ack low from here
    cyc(); Stall = 1'b0; settle();
    chk("c10_req_full", IMemReq, 0);
    // C11
    cyc(); settle();
    chk("c11_pc", IF_ID_PC, 32'h4);
    chk("c11_instr", IF_ID_Instr, D4);
    chk("c11_req", IMemReq, 1);
    chk("c11_retain", RetainPC, 1);
    // C12
    cyc(); settle();
    chk("c12_pc", IF_ID_PC, 32'h8);
    chk("c12_instr", IF_ID_Instr, D8);
    chk("c12_retain", RetainPC, 1);
    // C13
    cyc(); settle();
    chk("c13_valid", IF_ID_Valid, 0);
    chk("c13_req", IMemReq, 1);
    chk("c13_retain", RetainPC, 1);
    // C14: ack after three low cycles
    cyc(); IMemAck = 1'b1; settle();
    chk("c14_retain", RetainPC, 0);
    chk("c14_addr", IMemAddr, 32'hC);
    // C15
    cyc(); PC = 32'h10; IMemRValid = 1'b1; IMemRData = D12; settle();
    chk("c15_retain", RetainPC, 1);
    // C16: issue PC 0x10, pop 0xC
    cyc(); IMemAck = 1'b1; settle();
    chk("c16_addr", IMemAddr, 32'h10);
    // C17: flush while waiting for 0x10
    cyc(); PC = 32'h14; Flush = 1'b1; settle();
    chk("c17_retain", RetainPC, 0);
    chk("c17_req", IMemReq, 0);
    // C18: stale response arrives
    cyc(); PC = 32'h40; IMemRValid = 1'b1; IMemRData = 32'hDEAD_BEEF; settle();
    chk("c18_valid", IF_ID_Valid, 0);
    chk("c18_instr", IF_ID_Instr, NOP);
    chk("c18_pc_held", IF_ID_PC, 32'hC);
    chk("c18_req", IMemReq, 0);
    // C19: new path fetch
    cyc(); IMemAck = 1'b1; settle();
    chk("c19_req", IMemReq, 1);
    chk("c19_addr", IMemAddr, 32'h40);
    // C20
    cyc(); PC = 32'h44; IMemRValid = 1'b1; IMemRData = D40; settle();
    chk("c20_valid_dropped", IF_ID_Valid, 0);
    // C21
    cyc(); IMemAck = 1'b1; settle();
    chk("c21_addr", IMemAddr, 32'h44);
    // C22: fill two entries under stall
    cyc(); PC = 32'h48; Stall = 1'b1; IMemRValid = 1'b1; IMemRData = D44; settle();
    chk("c22_pc", IF_ID_PC, 32'h40);
    chk("c22_instr", IF_ID_Instr, D40);
    cyc(); IMemAck = 1'b1; settle();
    chk("c23_addr", IMemAddr, 32'h48);
    cyc(); PC = 32'h4C; IMemRValid = 1'b1; IMemRData = D48; settle();
    // C25: flush with stall, FIFO full
    cyc(); Flush = 1'b1; settle();
    chk("c25_retain", RetainPC, 0);
    chk("c25_req", IMemReq, 0);
    // C26
    cyc(); Stall = 1'b0; settle();
    chk("c26_valid", IF_ID_Valid, 0);
    chk("c26_instr", IF_ID_Instr, NOP);
    chk("c26_pc_held", IF_ID_PC, 32'h40);
    chk("c26_req_empty", IMemReq, 1);
    // C27: FIFO must be empty; issue 0x4C
    cyc(); IMemAck = 1'b1; settle();
    chk("c27_valid", IF_ID_Valid, 0);
    // C28: reset while waiting
    cyc(); Reset = 1'b1; PC = 32'hFFFF_FFFC; settle();
    chk("c28_req", IMemReq, 0);
    chk("c28_retain", RetainPC, 0);
    // C29: late response after release
    cyc(); Reset = 1'b0; IMemRValid = 1'b1; IMemRData = 32'h0000_0BAD; settle();
    chk("c29_retain", RetainPC, 0);
    chk("c29_req", IMemReq, 0);
    // C30
    cyc(); PC = 32'h0; IMemAck = 1'b1; settle();
    chk("c30_valid", IF_ID_Valid, 0);
    chk("c30_req", IMemReq, 1);
    chk("c30_addr", IMemAddr, 32'h0);
    // C31
    cyc(); PC = 32'h4; IMemRValid = 1'b1; IMemRData = D0; settle();
    chk("c31_valid", IF_ID_Valid, 0);
    // C32
    cyc(); settle();
    chk("c32_valid", IF_ID_Valid, 0);
    // C33
    cyc(); settle();
    chk("c33_valid", IF_ID_Valid, 1);
    chk("c33_pc", IF_ID_PC, 32'h0);
    chk("c33_instr", IF_ID_Instr, D0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
